cache_req_ctrl: RTL

- Sequences the direct-access data cache (set index, tag, 64-bit line) and the single memory port on behalf of two requesters: port 0 = data load, port 1 = instruction fetch.
- Round-robin arbitration picks one request at a time; the block performs the cache lookup and returns hit data.
- On a miss it issues a tagged memory load, waits for the matching response, fills the cache through its write port and returns the data.
- One outstanding transaction at a time; sits between the fetch/LSQ front ends and the cache + memory bus.

---
 rtl/cache_req_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cache_req_ctrl.sv
// Two-port (load / ifetch) request sequencer for a direct-mapped cache plus a single tagged memory port.
// Latency: hit response two cycles after req_ack; a miss adds the memory request and tagged-return time.
// Backpressure: one transaction in flight; other requests stay pending (no ack) until the FSM is back in IDLE.
module cache_req_ctrl #(
   parameter int ADDR_BITS    = 16,
   parameter int SET_BITS     = 3,
   parameter int TAG_BITS     = 10,
   parameter int MEM_TAG_BITS = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   input  logic [ADDR_BITS-1:0]    req_addr0,
   input  logic [ADDR_BITS-1:0]    req_addr1,
   output logic [1:0]              req_ack,
   output logic [1:0]              resp_valid,
   output logic [63:0]             resp_data,
   output logic                    busy,
   output logic [SET_BITS-1:0]     cache_rd_idx,
   output logic [TAG_BITS-1:0]     cache_rd_tag,
   input  logic [63:0]             cache_rd_data,
   input  logic                    cache_rd_valid,
   output logic                    cache_wr_en,
   output logic [SET_BITS-1:0]     cache_wr_idx,
   output logic [TAG_BITS-1:0]     cache_wr_tag,
   output logic [63:0]             cache_wr_data,
   output logic [1:0]              proc2mem_command,
   output logic [ADDR_BITS-1:0]    proc2mem_addr,
   input  logic [MEM_TAG_BITS-1:0] mem2proc_response,
   input  logic [63:0]             mem2proc_data,
   input  logic [MEM_TAG_BITS-1:0] mem2proc_tag
);

   typedef enum logic [1:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT} state_t;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_LOAD = 2'd1;

   state_t                  state;
   logic [SET_BITS-1:0]     idx_q;
   logic [TAG_BITS-1:0]     tag_q;
   logic                    grant_q;
   logic                    last_grant;
   logic [MEM_TAG_BITS-1:0] mem_tag;

   logic                    grant;
   logic                    req_go;
   logic                    fill_hit;
   logic [ADDR_BITS-1:0]    sel_addr;
   logic                    unused_offset;

   // Line offset bits never affect a line-granular access.
   assign unused_offset = ^{req_addr0[2:0], req_addr1[2:0]};

   // Round-robin pick: on a tie the port that did not win last time goes next.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b11)
         grant = ~last_grant;
      else if (req_valid[1])
         grant = 1'b1;
   end

   // Acceptance is only possible in IDLE and never while reset is being applied.
   assign req_go   = (state == IDLE) && reset && (req_valid != 2'b00);
   assign req_ack  = req_go ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign sel_addr = grant ? req_addr1 : req_addr0;
   assign busy     = (state != IDLE);

   // A fill happens only for the tag we are actually waiting on; tag 0 means nothing outstanding.
   assign fill_hit = (state == MEM_WAIT) && reset && (mem_tag != '0) && (mem2proc_tag == mem_tag);

   assign cache_rd_idx     = idx_q;
   assign cache_rd_tag     = tag_q;
   assign cache_wr_en      = fill_hit;
   assign cache_wr_idx     = idx_q;
   assign cache_wr_tag     = tag_q;
   assign cache_wr_data    = mem2proc_data;
   assign proc2mem_command = (state == MEM_REQ) ? CMD_LOAD : CMD_NONE;
   assign proc2mem_addr    = {tag_q, idx_q, 3'b000};

   // Transaction sequencer: arbitrate, look up, fetch on miss, fill and respond.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         idx_q      <= '0;
         tag_q      <= '0;
         grant_q    <= 1'b0;
         last_grant <= 1'b1;
         mem_tag    <= '0;
         resp_valid <= 2'b00;
         resp_data  <= 64'd0;
      end else begin
         resp_valid <= 2'b00;
         case (state)
            IDLE: begin
               if (req_go) begin
                  grant_q    <= grant;
                  last_grant <= grant;
                  idx_q      <= sel_addr[SET_BITS+2:3];
                  tag_q      <= sel_addr[ADDR_BITS-1:SET_BITS+3];
                  state      <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (cache_rd_valid) begin
                  resp_data  <= cache_rd_data;
                  resp_valid <= {grant_q, ~grant_q};
                  state      <= IDLE;
               end else begin
                  state <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               if (mem2proc_response != '0) begin
                  mem_tag <= mem2proc_response;
                  state   <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (fill_hit) begin
                  resp_data  <= mem2proc_data;
                  resp_valid <= {grant_q, ~grant_q};
                  mem_tag    <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
